// File: rtl/iter_right_shifter.sv
// ---------------------------------------------------------------------------
// iter_right_shifter
//
// Multi-cycle 32-bit right shifter, logical (SRL) or arithmetic (SRA).
// An operation is accepted from IDLE on `start`. The working register is
// then shifted one bit per clock in SHIFT until the captured count runs out.
// The result is registered on entry to DONE, which lasts one cycle.
//
// Optional build macro:
//   RSHIFT_FAST2_EN - SHIFT steps by two bits while at least two remain,
//                     giving ceil(shamt/2) SHIFT cycles. Results are identical
//                     to the default one-bit-per-cycle build.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   begin an operation (sampled only in IDLE)
//   data_in  in  32   operand, captured on start acceptance
//   shamt    in   5   shift amount 0..31, captured on start acceptance
//   arith    in   1   1 = SRA, 0 = SRL, captured on start acceptance
//   busy     out  1   high in SHIFT and DONE
//   done     out  1   one-cycle pulse, result valid
//   result   out 32   registered shift result, held until the next DONE
// ---------------------------------------------------------------------------
module iter_right_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic signed [DATA_W-1:0]  work;
    logic signed [DATA_W-1:0]  work_next;
    logic        [CNT_W-1:0]   cnt;
    logic        [CNT_W-1:0]   cnt_next;
    logic                      arith_q;
    logic                      arith_next;
    logic                      load_result;

    // One-bit right step. For SRA the fill is the current MSB, which never
    // changes during an operation, so it always equals the original bit 31.
    function automatic logic signed [DATA_W-1:0] shr1(
        input logic signed [DATA_W-1:0] v,
        input logic                     sra
    );
        shr1 = {sra & v[DATA_W-1], v[DATA_W-1:1]};
    endfunction

    // Two-bit right step; both fill bits are the sign (SRA) or zero (SRL).
    function automatic logic signed [DATA_W-1:0] shr2(
        input logic signed [DATA_W-1:0] v,
        input logic                     sra
    );
        shr2 = {{2{sra & v[DATA_W-1]}}, v[DATA_W-1:2]};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, datapath next values and outputs
    always_comb begin
        state_next  = state;
        work_next   = work;
        cnt_next    = cnt;
        arith_next  = arith_q;
        busy        = 1'b0;
        done        = 1'b0;
        load_result = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    work_next  = data_in;
                    cnt_next   = shamt;
                    arith_next = arith;
                    // A zero shift goes straight to DONE with the operand.
                    state_next = (shamt == '0) ? DONE : SHIFT;
                end
            end

            SHIFT: begin
                busy = 1'b1;
`ifdef RSHIFT_FAST2_EN
                if (cnt >= CNT_W'(2)) begin
                    work_next = shr2(work, arith_q);
                    cnt_next  = cnt - CNT_W'(2);
                end else begin
                    work_next = shr1(work, arith_q);
                    cnt_next  = cnt - CNT_W'(1);
                end
`else
                work_next = shr1(work, arith_q);
                cnt_next  = cnt - CNT_W'(1);
`endif
                if (cnt_next == '0) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // DONE always exits to IDLE, so DONE as next state means "entering".
        load_result = (state_next == DONE);
    end

    // Working register, count, captured mode and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            cnt     <= '0;
            arith_q <= 1'b0;
            result  <= '0;
        end else begin
            work    <= work_next;
            cnt     <= cnt_next;
            arith_q <= arith_next;
            if (load_result) begin
                result <= work_next;
            end
        end
    end

endmodule

// File: tb/tb_iter_right_shifter.sv
module tb_iter_right_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    iter_right_shifter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  n;
        logic        a;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [4:0] n);
`ifdef RSHIFT_FAST2_EN
        return (int'(n) + 1) / 2;
`else
        return int'(n);
`endif
    endfunction

    // Runs one operation starting from IDLE; returns with the DUT in the IDLE
    // cycle right after DONE so the next call starts back-to-back.
    task automatic run_op(input logic [31:0] d, input logic [4:0] n, input logic a,
                          input logic [31:0] exp, input string tag, input bit inject);
        logic [31:0] prev;
        int          lat;
        bit          seen;
        prev = result;
        @(negedge clk);
        data_in = d; shamt = n; arith = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end else begin
                chk({tag, " busy_in_shift"}, busy, 1'b1);
                chk({tag, " result_hold"}, result, prev);
            end
            if (inject && !seen && k == 2) begin
                data_in = ~d; shamt = 5'd1; arith = ~a; start = 1'b1;
            end
            if (inject && k == 3) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within 40 cycles", tag);
        end else begin
            chk({tag, " latency"}, lat, exp_latency(n));
            chk({tag, " result"}, result, exp);
            chk({tag, " busy_in_done"}, busy, 1'b1);
        end
        @(posedge clk); #1;
        chk({tag, " done_single"}, done, 1'b0);
        chk({tag, " busy_idle"}, busy, 1'b0);
        chk({tag, " result_held"}, result, exp);
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000};
        vecs[1]  = '{32'hF000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
        vecs[2]  = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678};
        vecs[3]  = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
        vecs[4]  = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
        vecs[5]  = '{32'h1234_5678, 5'd4,  1'b0, 32'h0123_4567};
        vecs[6]  = '{32'h8765_4321, 5'd4,  1'b1, 32'hF876_5432};
        vecs[7]  = '{32'h8765_4321, 5'd4,  1'b0, 32'h0876_5432};
        vecs[8]  = '{32'h7FFF_FFFF, 5'd1,  1'b1, 32'h3FFF_FFFF};
        vecs[9]  = '{32'hFFFF_FFFF, 5'd3,  1'b0, 32'h1FFF_FFFF};
        vecs[10] = '{32'h0000_0001, 5'd1,  1'b0, 32'h0000_0000};
        vecs[11] = '{32'h0000_FFFF, 5'd8,  1'b1, 32'h0000_00FF};
        vecs[12] = '{32'hC000_0000, 5'd2,  1'b1, 32'hF000_0000};

        rst_n = 1'b0; start = 1'b0; data_in = '0; shamt = '0; arith = 1'b0;
        #3;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].d, vecs[i].n, vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
        end

        // Reset in the middle of SHIFT
        @(negedge clk);
        data_in = 32'hFFFF_FFFF; shamt = 5'd20; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset busy", busy, 1'b0);
        chk("midreset done", done, 1'b0);
        chk("midreset result", result, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("midreset no_done", pulses, 0);
        chk("midreset result_after", result, 32'h0);

        // Start while busy is ignored
        run_op(32'h8000_0000, 5'd10, 1'b0, 32'h0020_0000, "busy_start", 1'b1);
        // Back-to-back: issued in the IDLE cycle right after the previous DONE
        run_op(32'hF000_000F, 5'd5, 1'b1, 32'hFF80_0000, "b2b_a", 1'b0);
        run_op(32'h0000_0100, 5'd0, 1'b0, 32'h0000_0100, "b2b_b", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_right_shifter.md
ITER_RIGHT_SHIFTER -- requirements
Module: iter_right_shifter

Interface
- No parameters; datapath width fixed at 32 bits, shift amount at 5 bits.
REQ-001 The block SHALL provide port `clk`, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL provide port `rst_n`, input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL provide port `start`, input, 1 bit, request to begin a shift; sampled only in IDLE.
REQ-004 The block SHALL provide port `data_in`, input, 32 bits, operand captured when `start` is accepted.
REQ-005 The block SHALL provide port `shamt`, input, 5 bits, shift amount 0..31 captured when `start` is accepted.
REQ-006 The block SHALL provide port `arith`, input, 1 bit, 1 = arithmetic right shift (SRA), 0 = logical right shift (SRL); captured when `start` is accepted.
REQ-007 The block SHALL provide port `busy`, output, 1 bit, high in SHIFT and DONE.
REQ-008 The block SHALL provide port `done`, output, 1 bit, one-cycle pulse marking `result` valid.
REQ-009 The block SHALL provide port `result`, output, 32 bits, registered shift result.

Function
REQ-010 The block SHALL implement exactly the states IDLE, SHIFT and DONE.
REQ-011 In IDLE with `start`=1, the block SHALL capture `data_in`, `arith` and `shamt` (as remaining count) at edge E0, then enter SHIFT if `shamt`>0 or DONE if `shamt`=0.
REQ-012 In SHIFT, each edge SHALL shift the working register right by one bit and decrement the count by one.
REQ-013 The bit shifted into the MSB SHALL be the working register's bit 31 when `arith`=1 and 0 when `arith`=0.
REQ-014 The block SHALL enter DONE on the edge at which the count reaches 0, i.e. after exactly `shamt` SHIFT edges (edges E1..En for `shamt`=n).
REQ-015 On entry to DONE, the block SHALL load `result` from the working register.
REQ-016 DONE SHALL last exactly one cycle with `done`=1, and SHALL then return to IDLE unconditionally.
REQ-017 `result` SHALL hold its value until the next entry to DONE and SHALL NOT change during SHIFT.
REQ-018 The block SHALL ignore `start` in SHIFT and DONE, and SHALL NOT change captured operands mid-operation.
REQ-019 `start`=1 in the IDLE cycle immediately following DONE SHALL be accepted, so back-to-back operations have no dead cycle beyond DONE.
REQ-020 For `shamt`=0, `result` SHALL equal `data_in` regardless of `arith`.
REQ-021 `busy` SHALL be low only in IDLE, and `done` SHALL be high only in DONE.

Reset
REQ-022 Assertion of `rst_n`=0 SHALL immediately force state IDLE, count 0, working register 0, `result`=0, `busy`=0 and `done`=0, including mid-operation.
REQ-023 On reset release, the first `start` SHALL be accepted no earlier than the first rising edge at which `rst_n`=1.

Configuration
REQ-024 When macro `RSHIFT_FAST2_EN` is defined, each SHIFT edge SHALL shift by 2 bits and decrement the count by 2 while count>=2, and by 1 bit when count=1, giving ceil(`shamt`/2) SHIFT cycles.
REQ-025 Under `RSHIFT_FAST2_EN`, the fill bits for a 2-bit step SHALL both equal the original bit 31 for SRA, or both be 0 for SRL.
REQ-026 When `RSHIFT_FAST2_EN` is undefined, the block SHALL use one-bit steps only (REQ-012); `result` values SHALL be identical in both builds.

Verification
REQ-027 Reset mid-SHIFT: assert `rst_n` low during SHIFT -> `busy`=0, `done`=0 and `result`=0 immediately, with no `done` pulse after release.
REQ-028 SRL: `data_in`=0x80000000, `shamt`=4, `arith`=0 -> `result`=0x08000000, with `done` high in the cycle after edge E4 (after E2 with the macro).
REQ-029 SRA: `data_in`=0xF0000000, `shamt`=31, `arith`=1 -> `result`=0xFFFFFFFF, with `done` after 31 SHIFT edges (16 with the macro).
REQ-030 Zero shift: `data_in`=0x12345678, `shamt`=0, `arith`=1 -> `result`=0x12345678, with `done` in the cycle after E0 and `busy` high for exactly that one cycle.
REQ-031 Start while busy: pulse `start` with new operands during SHIFT -> ignored, and the first operation's `result` is unchanged.
REQ-032 Back-to-back: a second `start` in the IDLE cycle right after DONE -> accepted, with a second `done` pulse and correct `result`.
